// File: rtl/stream_maxpool_2x2.sv
// Streaming 2x2 stride-2 max pool over a raster pixel stream with valid/ready on both sides.
// Define MAXPOOL_FRAME_LAST_EN to add a frame_last flag on the final pooled pixel of each frame.
module stream_maxpool_2x2 #(
  parameter int PIXEL_BIT_WIDTH = 8,
  parameter int IN_ROWS         = 4,
  parameter int IN_COLS         = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
  output logic                       out_valid,
  input  logic                       out_ready
`ifdef MAXPOOL_FRAME_LAST_EN
  ,
  output logic                       frame_last
`endif
);

  localparam int RW  = (IN_ROWS > 2) ? $clog2(IN_ROWS) : 1;
  localparam int CW  = (IN_COLS > 2) ? $clog2(IN_COLS) : 1;
  localparam int LBN = IN_COLS / 2;
  localparam int LW  = (LBN > 1) ? $clog2(LBN) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(IN_ROWS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(IN_COLS - 1);

  logic [RW-1:0]              r;
  logic [CW-1:0]              c;
  logic [PIXEL_BIT_WIDTH-1:0] h;
  logic [PIXEL_BIT_WIDTH-1:0] lb [LBN];
  logic                       accept;
  logic [LW-1:0]              lb_idx;
  logic [PIXEL_BIT_WIDTH-1:0] lb_rd;
  logic [PIXEL_BIT_WIDTH-1:0] pair_max;
  logic [PIXEL_BIT_WIDTH-1:0] col_max;

  // Pixels are two's complement, so the compare must be signed.
  function automatic logic [PIXEL_BIT_WIDTH-1:0] smax(
    input logic [PIXEL_BIT_WIDTH-1:0] a,
    input logic [PIXEL_BIT_WIDTH-1:0] b
  );
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign lb_idx   = LW'(c >> 1);
  assign lb_rd    = lb[lb_idx];
  assign pair_max = smax(h, pixel_in);
  assign col_max  = smax(lb_rd, pixel_in);

  // Line buffer holds the top-row pair maxima; its contents need no reset.
  always_ff @(posedge clk) begin
    if (accept && !r[0] && c[0]) begin
      lb[lb_idx] <= pair_max;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r         <= '0;
      c         <= '0;
      h         <= '0;
      pixel_out <= '0;
      out_valid <= 1'b0;
`ifdef MAXPOOL_FRAME_LAST_EN
      frame_last <= 1'b0;
`endif
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        case ({r[0], c[0]})
          2'b00: h <= pixel_in;
          2'b01: ;
          2'b10: h <= col_max;
          2'b11: begin
            pixel_out <= pair_max;
            out_valid <= 1'b1;
`ifdef MAXPOOL_FRAME_LAST_EN
            frame_last <= (r == R_LAST) && (c == C_LAST);
`endif
          end
          default: ;
        endcase
        if (c == C_LAST) begin
          c <= '0;
          r <= (r == R_LAST) ? '0 : r + 1'b1;
        end else begin
          c <= c + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_maxpool_2x2.sv
// Randomised self-checking bench for stream_maxpool_2x2 against a frame-level max-pool model.
// Exercises a 4x4 instance for most scenarios and an 8x8 instance for random handshaking.
module tb_stream_maxpool_2x2;

  logic clk = 1'b0;
  logic reset;

  logic [7:0] pin4, po4, pin8, po8;
  logic       iv4, ir4, ov4, or4;
  logic       iv8, ir8, ov8, or8;
`ifdef MAXPOOL_FRAME_LAST_EN
  logic       fl4, fl8;
`endif

  int total = 0;
  int bad   = 0;

  int         in_q[$];
  int         exp_q[$];
  int         exp_last_q[$];
  logic [7:0] got_q[$];
  logic       got_last_q[$];
  int         stalls;

  always #5 clk = ~clk;

  stream_maxpool_2x2 #(.PIXEL_BIT_WIDTH(8), .IN_ROWS(4), .IN_COLS(4)) dut4 (
    .clk(clk), .reset(reset), .pixel_in(pin4), .in_valid(iv4), .in_ready(ir4),
    .pixel_out(po4), .out_valid(ov4), .out_ready(or4)
`ifdef MAXPOOL_FRAME_LAST_EN
    , .frame_last(fl4)
`endif
  );

  stream_maxpool_2x2 #(.PIXEL_BIT_WIDTH(8), .IN_ROWS(8), .IN_COLS(8)) dut8 (
    .clk(clk), .reset(reset), .pixel_in(pin8), .in_valid(iv8), .in_ready(ir8),
    .pixel_out(po8), .out_valid(ov8), .out_ready(or8)
`ifdef MAXPOOL_FRAME_LAST_EN
    , .frame_last(fl8)
`endif
  );

  // Reference: slice in_q into whole frames and take the max of each 2x2 window.
  task automatic build_expected(input int rows, input int cols);
    int frame_sz, nf, base, m, v;
    exp_q.delete();
    exp_last_q.delete();
    frame_sz = rows * cols;
    nf = in_q.size() / frame_sz;
    for (int f = 0; f < nf; f++) begin
      for (int wr = 0; wr < rows / 2; wr++) begin
        for (int wc = 0; wc < cols / 2; wc++) begin
          base = f * frame_sz + 2 * wr * cols + 2 * wc;
          m = in_q[base];
          for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
              v = in_q[base + dr * cols + dc];
              if (v > m) m = v;
            end
          end
          exp_q.push_back(m);
          exp_last_q.push_back((wr == rows / 2 - 1 && wc == cols / 2 - 1) ? 1 : 0);
        end
      end
    end
  endtask

  // Streams in_q into the 4x4 instance and records every output beat.
  task automatic run4(input bit rand_hs, input int budget);
    int idx, tmp;
    idx = 0;
    stalls = 0;
    got_q.delete();
    got_last_q.delete();
    for (int cyc = 0; cyc < budget; cyc++) begin
      iv4 = (idx < in_q.size()) && (!rand_hs || ($urandom_range(0, 1) == 1));
      if (iv4) begin
        tmp  = in_q[idx];
        pin4 = tmp[7:0];
      end else begin
        pin4 = 8'($urandom);
      end
      or4 = !rand_hs || ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (ov4 && or4) begin
        got_q.push_back(po4);
`ifdef MAXPOOL_FRAME_LAST_EN
        got_last_q.push_back(fl4);
`endif
      end
      if (iv4 && !ir4) stalls++;
      if (iv4 && ir4) idx++;
      @(posedge clk);
      #1;
      if (idx >= in_q.size() && !ov4) break;
    end
    iv4 = 1'b0;
    or4 = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    iv4 = 1'b0; or4 = 1'b1; pin4 = '0;
    iv8 = 1'b0; or8 = 1'b1; pin8 = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ov4 !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %0b want 0", ov4); end
    total++; if (po4 !== 8'h00) begin bad++; $display("[TB] FAIL reset_pixel_out: got %0h want 0", po4); end
    total++; if (ir4 !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %0b want 1", ir4); end
    total++; if (ov8 !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid8: got %0b want 0", ov8); end
    reset = 1'b0;
  endtask

  task automatic test_index;
    int e;
    in_q.delete();
    for (int i = 0; i < 16; i++) in_q.push_back(i);
    build_expected(4, 4);
    run4(1'b0, 100);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("[TB] FAIL index_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      total++; if (got_q[i] !== e[7:0]) begin bad++; $display("[TB] FAIL index_px%0d: got %0d want %0d", i, got_q[i], e[7:0]); end
`ifdef MAXPOOL_FRAME_LAST_EN
      total++; if (got_last_q[i] !== exp_last_q[i][0]) begin bad++; $display("[TB] FAIL index_last%0d: got %0b want %0d", i, got_last_q[i], exp_last_q[i]); end
`endif
    end
    total++; if (stalls != 0) begin bad++; $display("[TB] FAIL index_throughput: stalls %0d want 0", stalls); end
  endtask

  task automatic test_signed;
    int e;
    in_q.delete();
    for (int i = 0; i < 16; i++) in_q.push_back(-128);
    in_q[0] = -3; in_q[1] = -1; in_q[4] = -8; in_q[5] = -128;
    build_expected(4, 4);
    run4(1'b0, 100);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("[TB] FAIL signed_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    total++; if (got_q[0] !== 8'hFF) begin bad++; $display("[TB] FAIL signed_first: got %0h want ff", got_q[0]); end
    for (int i = 1; i < exp_q.size(); i++) begin
      e = exp_q[i];
      total++; if (got_q[i] !== e[7:0]) begin bad++; $display("[TB] FAIL signed_px%0d: got %0h want %0h", i, got_q[i], e[7:0]); end
    end
  endtask

  task automatic test_backpressure;
    int idx, tmp, e;
    bit seen;
    in_q.delete();
    for (int i = 0; i < 16; i++) in_q.push_back(i);
    build_expected(4, 4);
    idx = 0; seen = 1'b0; or4 = 1'b0;
    for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
      iv4 = idx < in_q.size();
      tmp = in_q[idx]; pin4 = tmp[7:0];
      @(negedge clk);
      if (iv4 && ir4) idx++;
      @(posedge clk);
      #1;
      if (ov4) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("[TB] FAIL bp_first_output: got no out_valid want out_valid"); end
    e = exp_q[0];
    for (int k = 0; k < 6; k++) begin
      iv4 = 1'b1;
      tmp = in_q[idx]; pin4 = tmp[7:0];
      @(negedge clk);
      total++; if (ov4 !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid: got %0b want 1", ov4); end
      total++; if (po4 !== e[7:0]) begin bad++; $display("[TB] FAIL bp_hold: got %0d want %0d", po4, e[7:0]); end
      total++; if (ir4 !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready: got %0b want 0", ir4); end
      if (iv4 && ir4) idx++;
      @(posedge clk);
      #1;
    end
    total++; if (idx != 6) begin bad++; $display("[TB] FAIL bp_accepts: got %0d want 6", idx); end
    for (int k = 0; k < idx; k++) void'(in_q.pop_front());
    run4(1'b0, 100);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("[TB] FAIL bp_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      total++; if (got_q[i] !== e[7:0]) begin bad++; $display("[TB] FAIL bp_px%0d: got %0d want %0d", i, got_q[i], e[7:0]); end
    end
  endtask

  task automatic test_back_to_back;
    int e;
    in_q.delete();
    for (int i = 0; i < 32; i++) in_q.push_back(i);
    build_expected(4, 4);
    run4(1'b0, 200);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("[TB] FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      total++; if (got_q[i] !== e[7:0]) begin bad++; $display("[TB] FAIL b2b_px%0d: got %0d want %0d", i, got_q[i], e[7:0]); end
`ifdef MAXPOOL_FRAME_LAST_EN
      total++; if (got_last_q[i] !== exp_last_q[i][0]) begin bad++; $display("[TB] FAIL b2b_last%0d: got %0b want %0d", i, got_last_q[i], exp_last_q[i]); end
`endif
    end
    total++; if (stalls != 0) begin bad++; $display("[TB] FAIL b2b_throughput: stalls %0d want 0", stalls); end
  endtask

  task automatic test_reset_mid;
    int idx, e;
    idx = 0; or4 = 1'b0;
    for (int cyc = 0; cyc < 20 && idx < 6; cyc++) begin
      iv4 = 1'b1;
      pin4 = 8'(100 + idx);
      @(negedge clk);
      if (iv4 && ir4) idx++;
      @(posedge clk);
      #1;
    end
    iv4 = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      total++; if (ov4 !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_valid: got %0b want 0", ov4); end
    end
    reset = 1'b0;
    or4 = 1'b1;
    in_q.delete();
    for (int i = 0; i < 16; i++) in_q.push_back(i);
    build_expected(4, 4);
    run4(1'b0, 100);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("[TB] FAIL rst_mid_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      total++; if (got_q[i] !== e[7:0]) begin bad++; $display("[TB] FAIL rst_mid_px%0d: got %0d want %0d", i, got_q[i], e[7:0]); end
    end
  endtask

  task automatic test_random_frames;
    int e;
    in_q.delete();
    for (int i = 0; i < 48; i++) in_q.push_back(int'($urandom_range(0, 255)) - 128);
    build_expected(4, 4);
    run4(1'b1, 1000);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("[TB] FAIL rnd_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      total++; if (got_q[i] !== e[7:0]) begin bad++; $display("[TB] FAIL rnd_px%0d: got %0h want %0h", i, got_q[i], e[7:0]); end
`ifdef MAXPOOL_FRAME_LAST_EN
      total++; if (got_last_q[i] !== exp_last_q[i][0]) begin bad++; $display("[TB] FAIL rnd_last%0d: got %0b want %0d", i, got_last_q[i], exp_last_q[i]); end
`endif
    end
  endtask

  task automatic test_random_handshake;
    int idx, oi, tmp, e;
    bit prev_stall;
    logic [7:0] prev_po;
    in_q.delete();
    for (int f = 0; f < 20; f++) for (int i = 0; i < 64; i++) in_q.push_back(i);
    build_expected(8, 8);
    idx = 0; oi = 0; prev_stall = 1'b0; prev_po = '0;
    for (int cyc = 0; cyc < 20000 && oi < exp_q.size(); cyc++) begin
      iv8 = (idx < in_q.size()) && ($urandom_range(0, 1) == 1);
      if (iv8) begin
        tmp = in_q[idx]; pin8 = tmp[7:0];
      end else begin
        pin8 = 8'($urandom);
      end
      or8 = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (prev_stall) begin
        total++; if (!ov8 || po8 !== prev_po) begin bad++; $display("[TB] FAIL hs_stable: got v=%0b px=%0d want v=1 px=%0d", ov8, po8, prev_po); end
      end
      total++; if (ir8 !== (!ov8 || or8)) begin bad++; $display("[TB] FAIL hs_in_ready: got %0b want %0b", ir8, (!ov8 || or8)); end
      if (ov8 && or8) begin
        e = exp_q[oi];
        total++; if (po8 !== e[7:0]) begin bad++; $display("[TB] FAIL hs_px%0d: got %0d want %0d", oi, po8, e[7:0]); end
`ifdef MAXPOOL_FRAME_LAST_EN
        total++; if (fl8 !== exp_last_q[oi][0]) begin bad++; $display("[TB] FAIL hs_last%0d: got %0b want %0d", oi, fl8, exp_last_q[oi]); end
`endif
        oi++;
      end
      if (iv8 && ir8) idx++;
      prev_stall = ov8 && !or8;
      prev_po = po8;
      @(posedge clk);
      #1;
    end
    total++; if (oi != exp_q.size()) begin bad++; $display("[TB] FAIL hs_count: got %0d want %0d", oi, exp_q.size()); end
    iv8 = 1'b0; or8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (ov8 !== 1'b0) begin bad++; $display("[TB] FAIL hs_drain: got %0b want 0", ov8); end
  endtask

  initial begin
    test_reset;
    test_index;
    test_signed;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    test_random_frames;
    test_random_handshake;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
